alu_req_scheduler: RTL and testbench

// - Shares one 4-bit combinational ALU (add/sub/compare/AND, op select S[1:0]) between two requesters.
// - Arbitrates requests round-robin, drives the ALU S/A/B inputs, and registers the selected result.
// - Returns that result on a valid/ready response channel tagged with the requester ID.
// - Sits between the requesting control logic and the ALU instance; it is the only driver of the ALU inputs.

---
 rtl/alu_req_scheduler_pkg.sv | 43 ++++
 rtl/alu_req_scheduler_rr_arb2.sv | 22 ++
 rtl/alu_req_scheduler.sv | 114 +++++++++++
 tb/tb_alu_req_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_scheduler_pkg.sv
// Purpose : shared op codes, FSM state encoding and result packing for the ALU request scheduler.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package alu_req_scheduler_pkg;

  // Width of the shared ALU; the scheduler only supports this width.
  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } sched_state_e;

  // Selects the ALU output that belongs to the executed op and packs it
  // into a W+1 bit word. The top bit carries carry/borrow for add/sub.
  function automatic logic [ALU_W:0] pack_result(
      input alu_op_e          op,
      input logic             carry,
      input logic             borrow,
      input logic [ALU_W-1:0] sum,
      input logic [ALU_W-1:0] diff,
      input logic [2:0]       cmp,
      input logic [ALU_W-1:0] and_res
  );
    logic [ALU_W:0] res;
    case (op)
      OP_ADD:  res = {carry, sum};
      OP_SUB:  res = {borrow, diff};
      OP_CMP:  res = {{(ALU_W-2){1'b0}}, cmp};
      default: res = {1'b0, and_res};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arb2.sv
// Purpose : 2-way grant; a lone request wins, on contention the pointer side wins (side 0 when fixed_pr=1).
// Latency : combinational.
// Backpressure: none; the caller qualifies gnt with its own ready condition.
// Ports   : req[1:0] requests, ptr favoured side, fixed_pr forces side 0, gnt[1:0] one-hot or zero grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       fixed_pr,
  output logic [1:0] gnt
);

  logic favour;

  always_comb begin
    favour = fixed_pr ? 1'b0 : ptr;
    gnt    = req;
    if (req == 2'b11) begin
      gnt = favour ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Purpose : shares one 4-bit ALU between two requesters; arbitrates, drives the ALU inputs, registers the result.
// Latency : request accepted on one edge, ALU driven for the next cycle, rsp_valid high after the following edge (3 cycles/op min).
// Backpressure: one op in flight; req_ready stays 0 until the response is taken by rsp_ready.
// Ports   : clk/rst_n; req_valid/req_ready + req_op0/1, req_a0/1, req_b0/1 request side;
//           alu_s/a/b to the ALU, alu_carry/borrow/sum/diff/cmp/and back from it;
//           rsp_valid/rsp_ready + rsp_id, rsp_op, rsp_data response side.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter int W        = ALU_W,
  parameter bit FIXED_PR = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  // request side
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_op0,
  input  logic [1:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  // shared ALU
  output logic [1:0]   alu_s,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_carry,
  input  logic         alu_borrow,
  input  logic [W-1:0] alu_sum,
  input  logic [W-1:0] alu_diff,
  input  logic [2:0]   alu_cmp,
  input  logic [W-1:0] alu_and,
  // response side
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [1:0]   rsp_op,
  output logic [W:0]   rsp_data
);

  sched_state_e state_q;
  logic         rr_ptr_q;
  logic         id_q;
  logic [1:0]   gnt;
  logic         hs;

  rr_arb2 u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .fixed_pr (FIXED_PR),
    .gnt      (gnt)
  );

  // Ready is only offered in IDLE. It is also gated by rst_n so that no
  // accept is advertised while reset is held, even with requests pending.
  assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);

  // The ALU operand registers double as the latched request: they are
  // loaded on the accept edge (so they are live exactly during EXEC) and
  // cleared again when leaving EXEC to keep the ALU inputs quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 1'b0;
      id_q      <= 1'b0;
      alu_s     <= 2'b00;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_op    <= 2'b00;
      rsp_data  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            alu_s   <= gnt[1] ? req_op1 : req_op0;
            alu_a   <= gnt[1] ? req_a1  : req_a0;
            alu_b   <= gnt[1] ? req_b1  : req_b0;
            id_q    <= gnt[1];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= pack_result(alu_op_e'(alu_s), alu_carry, alu_borrow,
                                   alu_sum, alu_diff, alu_cmp, alu_and);
          rsp_op    <= alu_s;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          alu_s     <= 2'b00;
          alu_a     <= '0;
          alu_b     <= '0;
          // Hand priority to the other side for the next contention.
          if (!FIXED_PR) begin
            rr_ptr_q <= ~id_q;
          end
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Purpose : self-checking bench for alu_req_scheduler (round-robin instance plus a fixed-priority instance).
// Latency : n/a.
// Backpressure: rsp_ready is driven randomly and held low in directed holds.
module tb_alu_req_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_op0 = 2'b00, req_op1 = 2'b00;
  logic [3:0] req_a0 = 4'h0, req_a1 = 4'h0, req_b0 = 4'h0, req_b1 = 4'h0;
  logic       rsp_ready = 1'b0;

  logic [1:0] req_ready, alu_s, rsp_op;
  logic [3:0] alu_a, alu_b, alu_sum, alu_diff, alu_and;
  logic       alu_carry, alu_borrow, rsp_valid, rsp_id;
  logic [2:0] alu_cmp;
  logic [4:0] rsp_data;

  // fixed-priority instance: both requesters always valid, consumer always ready
  logic [1:0] fp_valid = 2'b11;
  logic       fp_rsp_ready = 1'b1;
  logic [1:0] fp_op = 2'b11;
  logic [3:0] fp_opnd = 4'h5;
  logic       fp_zero1 = 1'b0;
  logic [2:0] fp_zero3 = 3'b000;
  logic [3:0] fp_zero4 = 4'h0;
  logic [1:0] fp_ready, fp_alu_s, fp_rsp_op;
  logic [3:0] fp_alu_a, fp_alu_b;
  logic       fp_rsp_valid, fp_rsp_id;
  logic [4:0] fp_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int fp_grants = 0;
  logic [1:0] acc_q = 2'b00;
  logic       rst_seen = 1'b0;

  always #5 clk = ~clk;

  // ALU seen by the scheduler
  assign {alu_carry, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_borrow = (alu_a < alu_b);
  assign alu_diff   = alu_a - alu_b;
  assign alu_cmp    = {alu_a > alu_b, alu_a == alu_b, alu_a < alu_b};
  assign alu_and    = alu_a & alu_b;

  alu_req_scheduler #(.W(4), .FIXED_PR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry(alu_carry), .alu_borrow(alu_borrow), .alu_sum(alu_sum),
    .alu_diff(alu_diff), .alu_cmp(alu_cmp), .alu_and(alu_and),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_data(rsp_data)
  );

  alu_req_scheduler #(.W(4), .FIXED_PR(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(fp_valid), .req_ready(fp_ready),
    .req_op0(fp_op), .req_op1(fp_op),
    .req_a0(fp_opnd), .req_a1(fp_opnd), .req_b0(fp_opnd), .req_b1(fp_opnd),
    .alu_s(fp_alu_s), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
    .alu_carry(fp_zero1), .alu_borrow(fp_zero1), .alu_sum(fp_zero4),
    .alu_diff(fp_zero4), .alu_cmp(fp_zero3), .alu_and(fp_zero4),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
    .rsp_id(fp_rsp_id), .rsp_op(fp_rsp_op), .rsp_data(fp_rsp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Result the requester should receive, from the op definitions alone.
  function automatic logic [4:0] exp_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    case (op)
      2'd0:    return 5'(ia + ib);
      2'd1:    return {ia < ib, 4'((ia - ib + 16) % 16)};
      2'd2:    return {2'b00, ia > ib, ia == ib, ia < ib};
      default: return {1'b0, a & b};
    endcase
  endfunction

  always @(posedge clk) acc_q <= req_valid & req_ready;
  always @(negedge rst_n) rst_seen = 1'b1;

  // Reference model: at most one transaction in flight. m_age counts cycles
  // since acceptance: age 0 is the ALU cycle, age >= 1 the response is shown.
  logic       m_have = 1'b0, m_ptr = 1'b0, m_id = 1'b0;
  int         m_age = 0;
  logic [1:0] m_op = 2'b00;
  logic [3:0] m_a = 4'h0, m_b = 4'h0;
  logic [4:0] m_data = 5'h00;
  logic [1:0] exp_rdy;
  logic [9:0] exp_alu;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_have = 1'b0; m_ptr = 1'b0; rst_seen = 1'b0;
      chk("reset_outputs", {req_ready, alu_s, alu_a, alu_b, rsp_valid, rsp_id, rsp_op, rsp_data}, 32'h0);
      chk("fp_reset_ready", fp_ready, 2'b00);
    end else begin
      if (rst_seen) begin
        m_have = 1'b0; m_ptr = 1'b0; rst_seen = 1'b0;
      end
      exp_rdy = 2'b00;
      if (!m_have) exp_rdy = (req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", req_ready, exp_rdy);
      exp_alu = (m_have && m_age == 0) ? {m_op, m_a, m_b} : 10'h0;
      chk("alu_drive", {alu_s, alu_a, alu_b}, exp_alu);
      chk("rsp_valid", rsp_valid, m_have && m_age >= 1);
      if (m_have && m_age >= 1)
        chk("rsp_payload", {rsp_id, rsp_op, rsp_data}, {m_id, m_op, m_data});
      if (fp_ready != 2'b00) begin
        chk("fp_grant", fp_ready, 2'b01);
        fp_grants++;
      end
      // advance the model to the next cycle
      if (m_have) begin
        if (m_age >= 1 && rsp_ready) m_have = 1'b0;
        else m_age++;
      end else if (exp_rdy != 2'b00) begin
        m_have = 1'b1;
        m_age  = 0;
        m_id   = exp_rdy[1];
        m_op   = m_id ? req_op1 : req_op0;
        m_a    = m_id ? req_a1 : req_a0;
        m_b    = m_id ? req_b1 : req_b0;
        m_data = exp_result(m_op, m_a, m_b);
        m_ptr  = ~m_id;
      end
    end
  end

  task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    if (r == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  // Wait (bounded) for rsp_valid, dropping requests once they are accepted.
  task automatic wait_rsp(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      req_valid = req_valid & ~acc_q;
      #3;
      if (rsp_valid) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int         n_rsp;
  logic [1:0] got_id [2];
  logic [4:0] got_dat [2];

  initial begin
    // requests pending during reset must not be accepted
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // add 9+8 from requester 0
    @(negedge clk);
    set_req(0, 2'b00, 4'h9, 4'h8); req_valid = 2'b01; rsp_ready = 1'b1;
    #3 chk("t1_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;
    #3 chk("t1_exec_alu", {alu_s, alu_a, alu_b}, {2'b00, 4'h9, 4'h8});
    chk("t1_no_early_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    #3 chk("t1_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 5'h11});
    chk("t1_alu_quiet", {alu_s, alu_a, alu_b}, 10'h0);

    // sub 3-5 from requester 1
    @(negedge clk);
    set_req(1, 2'b01, 4'h3, 4'h5); req_valid = 2'b10;
    #3 chk("t2_ready", req_ready, 2'b10);
    chk("t2_alu_idle", alu_s, 2'b00);
    @(negedge clk); req_valid = 2'b00;
    #3 chk("t2_exec_alu", {alu_s, alu_a, alu_b}, {2'b01, 4'h3, 4'h5});
    @(negedge clk);
    #3 chk("t2_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 5'h1E});
    chk("t2_alu_after", alu_s, 2'b00);

    // both request AND F&A: grants 0 then 1
    @(negedge clk);
    set_req(0, 2'b11, 4'hF, 4'hA); set_req(1, 2'b11, 4'hF, 4'hA); req_valid = 2'b11;
    #3 chk("t3_first_grant", req_ready, 2'b01);
    n_rsp = 0;
    for (int i = 0; i < 12 && n_rsp < 2; i++) begin
      @(negedge clk);
      req_valid = req_valid & ~acc_q;
      #3;
      if (rsp_valid) begin
        got_id[n_rsp] = {1'b0, rsp_id};
        got_dat[n_rsp] = rsp_data;
        n_rsp++;
      end
    end
    chk("t3_rsp_count", n_rsp, 2);
    chk("t3_order", {got_id[0], got_id[1]}, 4'b0001);
    chk("t3_data", {got_dat[0], got_dat[1]}, {5'h0A, 5'h0A});

    // cmp 7,7 with consumer stalled for 5 cycles
    @(negedge clk);
    set_req(0, 2'b10, 4'h7, 4'h7); req_valid = 2'b01; rsp_ready = 1'b0;
    wait_rsp(8);
    chk("t4_rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_req(1, 2'b00, 4'h1, 4'h2); req_valid = 2'b11;
      #3 chk("t4_hold", {rsp_valid, rsp_id, rsp_op, rsp_data}, {1'b1, 1'b0, 2'b10, 5'h02});
      chk("t4_no_ready", req_ready, 2'b00);
    end
    @(negedge clk); req_valid = 2'b00; rsp_ready = 1'b1;
    #3 chk("t4_still_valid", rsp_valid, 1'b1);
    @(negedge clk);
    #3 chk("t4_released", rsp_valid, 1'b0);

    // reset while the response is waiting
    @(negedge clk);
    set_req(0, 2'b00, 4'h1, 4'h1); req_valid = 2'b01; rsp_ready = 1'b0;
    wait_rsp(8);
    chk("t6_rsp_seen", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk("t6_async_clear", {rsp_valid, req_ready, alu_s, rsp_data}, 32'h0);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3 chk("t6_no_stale", rsp_valid, 1'b0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (acc_q[r] || !req_valid[r]) begin
          if ($urandom_range(0, 99) < 55) begin
            set_req(r, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            req_valid[r] = 1'b1;
          end else begin
            req_valid[r] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 8) begin
          req_valid[r] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 65);
      if (c == 1500) begin
        #4 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #3 chk("fp_grant_count", fp_grants > 500, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
